// File: rtl/store_align_ctrl.sv
// Store sequencer: aligns one LSU store onto the 64-bit write bus and waits for the response.
// Define STORE_SPLIT_EN to split 8-byte-boundary-crossing stores into two beats.
module store_align_ctrl #(
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wstrb,
  input  logic              bus_bvalid,
  output logic              bus_bready,
  input  logic              bus_berr,
  output logic              done_valid,
  output logic              done_err
);

`ifdef STORE_SPLIT_EN
  typedef enum logic [2:0] {StIdle, StSend0, StWait0, StSend1, StWait1, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StSend0, StWait0, StDone} state_e;
`endif

  state_e state_q, state_d;
  logic   err_q, err_d;
  logic   accept;

  logic [2:0] off;
  logic [3:0] nbytes;
  logic [7:0] mask;
  logic       cross_in;

  // Alignment fields are computed from the incoming request and captured at acceptance.
  always_comb begin
    off = req_addr[2:0];
    unique case (req_size)
      2'b00:   begin nbytes = 4'd1; mask = 8'h01; end
      2'b01:   begin nbytes = 4'd2; mask = 8'h03; end
      2'b10:   begin nbytes = 4'd4; mask = 8'h0F; end
      default: begin nbytes = 4'd8; mask = 8'hFF; end
    endcase
    cross_in = (({1'b0, off} + nbytes) > 4'd8);
  end

  assign accept = req_valid && (state_q == StIdle);

`ifdef STORE_SPLIT_EN
  logic              cross_q;
  logic [ADDR_W-1:0] b1_addr_q;
  logic [63:0]       b1_wdata_q;
  logic [7:0]        b1_wstrb_q;
  logic              load_b1;

  assign load_b1 = (state_q == StWait0) && bus_bvalid && !bus_berr && cross_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cross_q    <= 1'b0;
      b1_addr_q  <= '0;
      b1_wdata_q <= '0;
      b1_wstrb_q <= '0;
    end else if (accept) begin
      cross_q    <= cross_in;
      b1_addr_q  <= {req_addr[ADDR_W-1:3], 3'b000} + ADDR_W'(8);
      // off == 0 shifts by the full width and yields zero, as required.
      b1_wdata_q <= req_data >> (7'd64 - {1'b0, off, 3'b000});
      b1_wstrb_q <= mask >> (4'd8 - {1'b0, off});
    end
  end
`endif

  // Bus beat registers only change at acceptance or between beats, so they hold under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else if (accept) begin
      bus_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
      bus_wdata <= req_data << {off, 3'b000};
      bus_wstrb <= mask << off;
    end
`ifdef STORE_SPLIT_EN
    else if (load_b1) begin
      bus_addr  <= b1_addr_q;
      bus_wdata <= b1_wdata_q;
      bus_wstrb <= b1_wstrb_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          err_d   = 1'b0;
          state_d = StSend0;
`ifndef STORE_SPLIT_EN
          if (cross_in) begin
            err_d   = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StSend0: if (bus_ready) state_d = StWait0;
      StWait0: begin
        if (bus_bvalid) begin
          err_d   = bus_berr;
          state_d = StDone;
`ifdef STORE_SPLIT_EN
          if (!bus_berr && cross_q) state_d = StSend1;
`endif
        end
      end
`ifdef STORE_SPLIT_EN
      StSend1: if (bus_ready) state_d = StWait1;
      StWait1: begin
        if (bus_bvalid) begin
          err_d   = bus_berr;
          state_d = StDone;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    bus_valid  = (state_q == StSend0);
    bus_bready = (state_q == StWait0);
`ifdef STORE_SPLIT_EN
    bus_valid  = bus_valid  || (state_q == StSend1);
    bus_bready = bus_bready || (state_q == StWait1);
`endif
    done_valid = (state_q == StDone);
    done_err   = (state_q == StDone) && err_q;
  end

endmodule

// File: tb/tb_store_align_ctrl.sv
// Directed bench for store_align_ctrl; expectations adapt to the STORE_SPLIT_EN build.
module tb_store_align_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        bus_valid;
  logic        bus_ready;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_bvalid;
  logic        bus_bready;
  logic        bus_berr;
  logic        done_valid;
  logic        done_err;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int hs_base;
  int done_base;

  store_align_ctrl #(.ADDR_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_size   (req_size),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_bvalid (bus_bvalid),
    .bus_bready (bus_bready),
    .bus_berr   (bus_berr),
    .done_valid (done_valid),
    .done_err   (done_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_valid && bus_ready) hs_cnt <= hs_cnt + 1;
    if (done_valid) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_data  = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [63:0] a, input logic [7:0] s,
                      input logic [63:0] d);
    check({tag, "_valid"}, 64'(bus_valid), 64'd1);
    check({tag, "_addr"}, bus_addr, a);
    check({tag, "_wstrb"}, 64'(bus_wstrb), 64'(s));
    check({tag, "_wdata"}, bus_wdata, d);
  endtask

  task automatic respond(input logic err);
    bus_bvalid = 1'b1;
    bus_berr   = err;
    tick();
    bus_bvalid = 1'b0;
    bus_berr   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    bus_ready = 1'b0; bus_bvalid = 1'b0; bus_berr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_bus_valid", 64'(bus_valid), 64'd0);
    check("rst_bus_bready", 64'(bus_bready), 64'd0);
    check("rst_done_valid", 64'(done_valid), 64'd0);
    check("rst_done_err", 64'(done_err), 64'd0);
    check("rst_bus_addr", bus_addr, 64'd0);
    check("rst_bus_wdata", bus_wdata, 64'd0);
    check("rst_bus_wstrb", 64'(bus_wstrb), 64'd0);

    // Aligned word
    bus_ready = 1'b1;
    accept(64'h1000, 2'b10, 64'hDEADBEEF);
    beat("word", 64'h1000, 8'h0F, 64'h00000000DEADBEEF);
    check("word_req_ready", 64'(req_ready), 64'd0);
    tick();
    check("word_valid_drop", 64'(bus_valid), 64'd0);
    check("word_bready", 64'(bus_bready), 64'd1);
    respond(1'b0);
    check("word_done", 64'(done_valid), 64'd1);
    check("word_err", 64'(done_err), 64'd0);
    check("word_done_req_ready", 64'(req_ready), 64'd0);
    tick();
    check("word_done_pulse", 64'(done_valid), 64'd0);
    check("word_idle_ready", 64'(req_ready), 64'd1);

    // Offset byte; bvalid coinciding with the beat handshake must be ignored
    accept(64'h2005, 2'b00, 64'hA5);
    beat("byte", 64'h2000, 8'h20, 64'h0000A50000000000);
    bus_bvalid = 1'b1;
    tick();
    check("byte_early_bvalid_wait", 64'(bus_bready), 64'd1);
    check("byte_early_bvalid_nodone", 64'(done_valid), 64'd0);
    tick();
    bus_bvalid = 1'b0;
    check("byte_done", 64'(done_valid), 64'd1);
    check("byte_err", 64'(done_err), 64'd0);
    tick();

    // Backpressure on a half store
    bus_ready = 1'b0;
    hs_base = hs_cnt;
    accept(64'h3002, 2'b01, 64'hBEEF);
    for (int i = 0; i < 5; i++) begin
      beat("stall", 64'h3000, 8'h0C, 64'h00000000BEEF0000);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    bus_ready = 1'b1;
    tick();
    check("stall_hs_count", 64'(hs_cnt - hs_base), 64'd1);
    check("stall_valid_drop", 64'(bus_valid), 64'd0);
    respond(1'b0);
    check("stall_done", 64'(done_valid), 64'd1);
    tick();

    // Boundary: offset 4 word exactly fills the doubleword, single beat
    hs_base = hs_cnt;
    accept(64'h6004, 2'b10, 64'hCAFEF00D);
    beat("fill", 64'h6000, 8'hF0, 64'hCAFEF00D00000000);
    tick();
    respond(1'b0);
    check("fill_done", 64'(done_valid), 64'd1);
    check("fill_err", 64'(done_err), 64'd0);
    check("fill_hs_count", 64'(hs_cnt - hs_base), 64'd1);
    tick();

    // Aligned double with bus error: never crosses, error reported
    accept(64'h5000, 2'b11, 64'h0123456789ABCDEF);
    beat("dbl", 64'h5000, 8'hFF, 64'h0123456789ABCDEF);
    tick();
    respond(1'b1);
    check("dbl_done", 64'(done_valid), 64'd1);
    check("dbl_err", 64'(done_err), 64'd1);
    tick();

    // Crossing double store
    hs_base = hs_cnt;
    done_base = done_cnt;
    accept(64'h4006, 2'b11, 64'h1122334455667788);
`ifdef STORE_SPLIT_EN
    beat("x_b0", 64'h4000, 8'hC0, 64'h7788000000000000);
    tick();
    respond(1'b0);
    beat("x_b1", 64'h4008, 8'h3F, 64'h0000112233445566);
    check("x_b1_nodone", 64'(done_valid), 64'd0);
    tick();
    check("x_b1_bready", 64'(bus_bready), 64'd1);
    respond(1'b0);
    check("x_done", 64'(done_valid), 64'd1);
    check("x_err", 64'(done_err), 64'd0);
    tick();
    check("x_hs_count", 64'(hs_cnt - hs_base), 64'd2);
    check("x_done_count", 64'(done_cnt - done_base), 64'd1);

    // Crossing store with error on beat 0: no beat 1
    hs_base = hs_cnt;
    accept(64'h5006, 2'b10, 64'h0BADCAFE);
    beat("xe_b0", 64'h5000, 8'hC0, 64'hCAFE000000000000);
    tick();
    respond(1'b1);
    check("xe_done", 64'(done_valid), 64'd1);
    check("xe_err", 64'(done_err), 64'd1);
    check("xe_no_beat1", 64'(bus_valid), 64'd0);
    tick();
    check("xe_hs_count", 64'(hs_cnt - hs_base), 64'd1);
`else
    check("x_done", 64'(done_valid), 64'd1);
    check("x_err", 64'(done_err), 64'd1);
    check("x_no_beat", 64'(bus_valid), 64'd0);
    tick();
    check("x_idle", 64'(req_ready), 64'd1);
    check("x_hs_count", 64'(hs_cnt - hs_base), 64'd0);
    check("x_done_count", 64'(done_cnt - done_base), 64'd1);
`endif

    // Reset asserted in WAIT0
    done_base = done_cnt;
    accept(64'h7000, 2'b00, 64'h11);
    tick();
    check("rw_bready", 64'(bus_bready), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_req_ready", 64'(req_ready), 64'd1);
    check("rw_bus_valid", 64'(bus_valid), 64'd0);
    check("rw_bus_bready", 64'(bus_bready), 64'd0);
    check("rw_done_valid", 64'(done_valid), 64'd0);
    tick();
    check("rw_no_done", 64'(done_cnt - done_base), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
